// File: rtl/sample_reader_if.sv
// Bus bundle between sample_reader and its environment: the state-watcher
// handshake, the asynchronous sample-memory read port and the uart_tx byte port.
interface sample_reader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  activate;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_oe;
  logic [7:0]            mem_data;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_active;
  logic                  tx_done;

  modport master (
    input  activate, mem_data, tx_active, tx_done,
    output done, mem_addr, mem_oe, tx_data, tx_start
  );

  modport slave (
    output activate, mem_data, tx_active, tx_done,
    input  done, mem_addr, mem_oe, tx_data, tx_start
  );
endinterface

// File: rtl/sample_reader.sv
// Streams a captured sample block out of the sampling memory as one framed
// uart_tx packet: HEADER, LEN, samples 0..NUM_SAMPLES-1, 8-bit wrapping checksum.
module sample_reader #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          NUM_SAMPLES = 256,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  sample_reader_if.master   bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SEND, S_WAIT, S_FIN} state_t;
  typedef enum logic [1:0] {P_HDR, P_LEN, P_SMP, P_CSUM} phase_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [7:0]            LEN_BYTE  = 8'(NUM_SAMPLES - 1);

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [7:0]            csum_q,  csum_d;
  logic [7:0]            txd_q,   txd_d;
  logic                  rearm_q, rearm_d;
  logic [7:0]            byte_sel;

  // State register
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a low activate anywhere except IDLE/FIN aborts the frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.activate && rearm_q) state_d = S_ARM;
      S_ARM: begin
        if (!bus.activate)       state_d = S_IDLE;
        else if (!bus.tx_active) state_d = S_SEND;
      end
      S_SEND: state_d = bus.activate ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!bus.activate)    state_d = S_IDLE;
        else if (bus.tx_done) state_d = (phase_q == P_CSUM) ? S_FIN : S_SEND;
      end
      S_FIN:  if (!bus.activate) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (phase_q)
      P_HDR:   byte_sel = HEADER;
      P_LEN:   byte_sel = LEN_BYTE;
      P_SMP:   byte_sel = bus.mem_data;
      default: byte_sel = csum_q;
    endcase
  end

  // Byte sequencing, checksum and re-arm tracking
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    txd_d   = txd_q;
    rearm_d = rearm_q;
    if (!bus.activate)
      rearm_d = 1'b1;
    else if (state_q == S_IDLE && state_d == S_ARM)
      rearm_d = 1'b0;
    if (state_q == S_SEND) begin
      txd_d = byte_sel;
      if (phase_q == P_SMP) csum_d = csum_q + bus.mem_data;
    end
    if (state_q == S_WAIT && state_d == S_SEND) begin
      unique case (phase_q)
        P_HDR: phase_d = P_LEN;
        P_LEN: phase_d = P_SMP;
        P_SMP: begin
          if (addr_q == LAST_ADDR) phase_d = P_CSUM;
          else                     addr_d  = addr_q + ADDR_ONE;
        end
        default: phase_d = phase_q;
      endcase
    end
    // Leaving for IDLE (frame end or abort) always starts the next frame clean
    if (state_d == S_IDLE) begin
      phase_d = P_HDR;
      addr_d  = '0;
      csum_d  = '0;
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      phase_q <= P_HDR;
      addr_q  <= '0;
      csum_q  <= '0;
      txd_q   <= '0;
      rearm_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      txd_q   <= txd_d;
      rearm_q <= rearm_d;
    end
  end

  // Outputs; tx_data shows the selected byte live in SEND and holds it afterwards
  always_comb begin
    bus.tx_start = (state_q == S_SEND);
    bus.done     = (state_q == S_FIN);
    bus.mem_oe   = (phase_q == P_SMP) && (state_q == S_SEND || state_q == S_WAIT);
    bus.mem_addr = addr_q;
    bus.tx_data  = (state_q == S_SEND) ? byte_sel : txd_q;
  end

endmodule

// File: tb/tb_sample_reader.sv
// Bench for sample_reader: two instances (4 and 256 samples) against a
// framed-packet reference model, a behavioural uart_tx and a scoreboard monitor.
module tb_sample_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit         act  [2];
  bit         hold [2];
  bit         busy [2];
  bit         txd  [2];
  int         cnt  [2];
  bit         live [2];
  bit         prev_txd [2];
  bit         prev_start [2];
  int         starts [2];
  logic [7:0] mem [2][256];
  logic [7:0] exp_q [2][$];

  logic       tx_start_w  [2];
  logic       tx_active_w [2];
  logic       done_w      [2];
  logic       mem_oe_w    [2];
  logic [7:0] tx_data_w   [2];
  logic [7:0] mem_addr_w  [2];

  function automatic int nsamp(input int g);
    return (g == 0) ? 4 : 256;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    sample_reader_if #(.ADDR_WIDTH(8)) ifc ();
    sample_reader #(.ADDR_WIDTH(8), .NUM_SAMPLES((g == 0) ? 4 : 256), .HEADER(8'hA5)) dut (
      .clk_50mhz (clk),
      .reset     (rst_n),
      .bus       (ifc.master)
    );
    assign ifc.activate   = act[g];
    assign tx_active_w[g] = busy[g] | hold[g];
    assign ifc.tx_active  = tx_active_w[g];
    assign ifc.tx_done    = txd[g];
    assign ifc.mem_data   = mem[g][ifc.mem_addr];
    assign tx_start_w[g]  = ifc.tx_start;
    assign done_w[g]      = ifc.done;
    assign mem_oe_w[g]    = ifc.mem_oe;
    assign tx_data_w[g]   = ifc.tx_data;
    assign mem_addr_w[g]  = ifc.mem_addr;
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // uart_tx stand-in: busy for 1..4 cycles per byte, then a one-cycle tx_done
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      txd[g] <= 1'b0;
      if (busy[g]) begin
        if (cnt[g] <= 1) begin
          busy[g] <= 1'b0;
          txd[g]  <= 1'b1;
        end else begin
          cnt[g] <= cnt[g] - 1;
        end
      end
      if (tx_start_w[g]) begin
        busy[g] <= 1'b1;
        cnt[g]  <= int'($urandom_range(1, 4));
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_n) begin
        if (prev_txd[g] && live[g]) begin
          if (exp_q[g].size() != 0) check("next_start_latency", int'(tx_start_w[g]), 1);
          else begin
            check("done_after_last_tx_done", int'(done_w[g]), 1);
            live[g] = 1'b0;
          end
        end
        if (tx_start_w[g]) begin
          starts[g]++;
          check("start_while_active", int'(tx_active_w[g]), 0);
          check("start_width", int'(prev_start[g]), 0);
          if (mem_oe_w[g]) check("addr_range", int'(int'(mem_addr_w[g]) < nsamp(g)), 1);
          if (exp_q[g].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_tx_start: inst %0d got data %0h, want no start", g, tx_data_w[g]);
          end else begin
            check("tx_data", int'(tx_data_w[g]), int'(exp_q[g].pop_front()));
          end
        end
      end
      prev_txd[g]   = txd[g];
      prev_start[g] = tx_start_w[g];
    end
  end

  task automatic push_frame(input int g);
    int sum = 0;
    exp_q[g].push_back(8'hA5);
    exp_q[g].push_back(8'(nsamp(g) - 1));
    for (int i = 0; i < nsamp(g); i++) begin
      exp_q[g].push_back(mem[g][i]);
      sum += int'(mem[g][i]);
    end
    exp_q[g].push_back(8'(sum % 256));
    live[g] = 1'b1;
  endtask

  task automatic wait_done(input int g);
    int i = 0;
    while (!done_w[g] && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", int'(done_w[g]), 1);
  endtask

  task automatic run_frame(input int g);
    int s;
    push_frame(g);
    s = starts[g];
    act[g] = 1'b1;
    wait_done(g);
    check("frame_all_bytes_sent", exp_q[g].size(), 0);
    check("frame_start_count", starts[g] - s, nsamp(g) + 3);
  endtask

  task automatic lower(input int g);
    act[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_mem(input int g);
    for (int i = 0; i < 256; i++) mem[g][i] = 8'($urandom);
  endtask

  task automatic wait_starts(input int g, input int target);
    int i = 0;
    while (starts[g] < target && i < 2000) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("reached_start_count", int'(starts[g] >= target), 1);
  endtask

  task automatic check_reset_outputs(input int g);
    check("rst_done", int'(done_w[g]), 0);
    check("rst_tx_start", int'(tx_start_w[g]), 0);
    check("rst_tx_data", int'(tx_data_w[g]), 0);
    check("rst_mem_addr", int'(mem_addr_w[g]), 0);
    check("rst_mem_oe", int'(mem_oe_w[g]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 8'(i);
      mem[1][i] = 8'hFF;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Memory[i]=i, 4 samples: A5 03 00 01 02 03 06, header one cycle after ARM
    push_frame(0);
    s = starts[0];
    act[0] = 1'b1;
    @(negedge clk);
    check("arm_cycle_no_start", int'(tx_start_w[0]), 0);
    @(negedge clk);
    check("header_start", int'(tx_start_w[0]), 1);
    check("header_data", int'(tx_data_w[0]), 'hA5);
    wait_done(0);
    check("frame_all_bytes_sent", exp_q[0].size(), 0);
    check("frame_start_count", starts[0] - s, 7);

    // activate held high after FIN: no second frame
    s = starts[0];
    repeat (10) @(negedge clk);
    check("done_held", int'(done_w[0]), 1);
    check("no_second_frame", starts[0] - s, 0);
    lower(0);
    check("done_falls", int'(done_w[0]), 0);
    rand_mem(0);
    run_frame(0);

    repeat (4) begin
      lower(0);
      rand_mem(0);
      run_frame(0);
    end

    // tx_active busy when activate rises
    lower(0);
    rand_mem(0);
    hold[0] = 1'b1;
    push_frame(0);
    s = starts[0];
    act[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("gate_no_start", starts[0] - s, 0);
    hold[0] = 1'b0;
    @(negedge clk);
    check("gate_release_start", int'(tx_start_w[0]), 1);
    check("gate_release_hdr", int'(tx_data_w[0]), 'hA5);
    wait_done(0);
    check("gate_frame_sent", exp_q[0].size(), 0);

    // Abort after the 2nd sample's tx_start
    lower(0);
    rand_mem(0);
    push_frame(0);
    s = starts[0];
    act[0] = 1'b1;
    wait_starts(0, s + 4);
    act[0] = 1'b0;
    exp_q[0].delete();
    live[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_more_starts", starts[0] - s, 4);
    check("abort_done_low", int'(done_w[0]), 0);
    rand_mem(0);
    run_frame(0);

    // Asynchronous reset mid-frame
    lower(0);
    rand_mem(0);
    push_frame(0);
    s = starts[0];
    act[0] = 1'b1;
    wait_starts(0, s + 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    exp_q[0].delete();
    live[0] = 1'b0;
    act[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_mem(0);
    run_frame(0);

    // 256 samples of FF: LEN=FF, CSUM wraps to 00, 259 bytes
    run_frame(1);
    lower(1);
    rand_mem(1);
    run_frame(1);

    lower(0);
    lower(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
